// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, false-start rejection and framing/break handling, feeding a
// show-ahead FIFO drained over valid/ready. Define UART_RX_PARITY_EN to add a parity bit and check.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ser_rx,
  input  logic [DIV_WIDTH-1:0]          cfg_divider,
  input  logic                          cfg_parity_odd,
  output logic [DATA_BITS-1:0]          out_data,
  output logic                          out_frame_err,
  output logic                          out_parity_err,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overrun,
  input  logic                          overrun_clr
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = DATA_BITS + 2;
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_ON = 1'b1;
`else
  localparam logic PARITY_ON = 1'b0;
  logic unused_parity_cfg;
  assign unused_parity_cfg = cfg_parity_odd;
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;

  logic rx_meta_reg, rx_s_reg;
  state_t state_reg, state_next;
  logic [DIV_WIDTH-1:0] divcnt_reg, divcnt_next;
  logic [3:0] bitcnt_reg, bitcnt_next;
  logic [DATA_BITS-1:0] shreg_reg, shreg_next;
  logic perr_reg, perr_next;
  logic push;
  logic bit_tick, half_tick;
  logic [EW-1:0] push_entry;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= ser_rx;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  assign bit_tick  = (divcnt_reg == cfg_divider);
  assign half_tick = (divcnt_reg == (cfg_divider >> 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      divcnt_reg <= '0;
      bitcnt_reg <= '0;
      shreg_reg  <= '0;
      perr_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      divcnt_reg <= divcnt_next;
      bitcnt_reg <= bitcnt_next;
      shreg_reg  <= shreg_next;
      perr_reg   <= perr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    divcnt_next = divcnt_reg + DIV_WIDTH'(1);
    bitcnt_next = bitcnt_reg;
    shreg_next  = shreg_reg;
    perr_next   = perr_reg;
    push        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!rx_s_reg) begin
          state_next  = START;
          divcnt_next = '0;
        end
      end
      START: begin
        // Line must still be low at mid start bit, otherwise it was a glitch.
        if (half_tick) begin
          divcnt_next = '0;
          if (rx_s_reg) begin
            state_next = IDLE;
          end else begin
            state_next  = DATA;
            bitcnt_next = '0;
            perr_next   = 1'b0;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          divcnt_next = '0;
          shreg_next  = {rx_s_reg, shreg_reg[DATA_BITS-1:1]};
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          divcnt_next = '0;
          perr_next   = ((^shreg_reg) ^ rx_s_reg) != cfg_parity_odd;
          state_next  = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          divcnt_next = '0;
          push        = 1'b1;
          state_next  = rx_s_reg ? IDLE : BRK;
        end
      end
      BRK: begin
        if (rx_s_reg) begin
          state_next  = IDLE;
          divcnt_next = '0;
        end
      end
      default: begin
        state_next  = IDLE;
        divcnt_next = '0;
      end
    endcase
  end

  assign push_entry = {perr_reg & PARITY_ON, !rx_s_reg, shreg_reg};

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic full_reg, overrun_reg;
  logic empty, pop, do_push, drop;
  logic [EW-1:0] head;

  assign empty     = (wr_ptr_reg == rd_ptr_reg) && !full_reg;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  // A push into a full FIFO still lands if the head leaves in the same cycle.
  assign do_push   = push && (!full_reg || pop);
  assign drop      = push && full_reg && !pop;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      full_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      if (do_push && !pop && ((wr_ptr_reg + PW'(1)) == rd_ptr_reg)) begin
        full_reg <= 1'b1;
      end else if (pop && !do_push) begin
        full_reg <= 1'b0;
      end
      if (drop) begin
        overrun_reg <= 1'b1;
      end else if (overrun_clr) begin
        overrun_reg <= 1'b0;
      end
    end
  end

  assign head           = out_valid ? mem[rd_ptr_reg] : '0;
  assign out_data       = head[DATA_BITS-1:0];
  assign out_frame_err  = head[DATA_BITS];
  assign out_parity_err = head[EW-1] & PARITY_ON;
  assign fifo_level     = full_reg ? (PW+1)'(FIFO_DEPTH) : {1'b0, wr_ptr_reg - rd_ptr_reg};
  assign overrun        = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: table-driven single frames plus glitch, break, overrun and
// mid-frame reset sequences. Honours UART_RX_PARITY_EN when the build defines it.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
  localparam int DB  = 8;
  localparam int FD  = 4;
  localparam int DW  = 32;
  localparam int DIV = 86;
  localparam int BIT = DIV + 1;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_rx = 1'b1;
  logic [DW-1:0] cfg_divider = DW'(DIV);
  logic cfg_parity_odd = 1'b0;
  logic out_ready = 1'b0;
  logic overrun_clr = 1'b0;
  logic [DB-1:0] out_data;
  logic out_frame_err, out_parity_err, out_valid, overrun;
  logic [$clog2(FD):0] fifo_level;

  uart_rx_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(FD), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .ser_rx(ser_rx), .cfg_divider(cfg_divider),
    .cfg_parity_odd(cfg_parity_odd), .out_data(out_data), .out_frame_err(out_frame_err),
    .out_parity_err(out_parity_err), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_level(fifo_level), .overrun(overrun), .overrun_clr(overrun_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic line_bits(input logic v, input int n);
    ser_rx = v;
    repeat (n * BIT) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_level,
                            input int stop_bits);
    line_bits(1'b0, 1);
    for (int i = 0; i < DB; i++) line_bits(d[i], 1);
    if (PAR) line_bits((^d) ^ cfg_parity_odd ^ par_flip, 1);
    line_bits(stop_level, stop_bits);
    ser_rx = 1'b1;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par_flip;
    logic       stop_level;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];
  logic [7:0] partial;

  initial begin
    vecs[0] = '{data: 8'hA5, par_flip: 1'b0, stop_level: 1'b1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h00, par_flip: 1'b0, stop_level: 1'b1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[2] = '{data: 8'hFF, par_flip: 1'b0, stop_level: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h81, par_flip: 1'b0, stop_level: 1'b0, exp_data: 8'h81, exp_ferr: 1'b1};
    vecs[4] = '{data: 8'h07, par_flip: 1'b0, stop_level: 1'b1, exp_data: 8'h07, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'h07, par_flip: 1'b1, stop_level: 1'b1, exp_data: 8'h07, exp_ferr: 1'b0};

    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset fifo_level", fifo_level, 0);
    check("reset overrun", overrun, 0);
    check("reset out_data", out_data, 0);
    check("reset flags", {out_parity_err, out_frame_err}, 0);
    reset = 1'b0;
    line_bits(1'b1, 2);

    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].data, vecs[i].par_flip, vecs[i].stop_level, 1);
      line_bits(1'b1, 2);
      check($sformatf("vec%0d out_valid", i), out_valid, 1);
      check($sformatf("vec%0d fifo_level", i), fifo_level, 1);
      check($sformatf("vec%0d out_data", i), out_data, vecs[i].exp_data);
      check($sformatf("vec%0d frame_err", i), out_frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d parity_err", i), out_parity_err, PAR & vecs[i].par_flip);
      pop_one();
      check($sformatf("vec%0d drained", i), out_valid, 0);
    end

    ser_rx = 1'b0;
    repeat (30) @(negedge clk);
    line_bits(1'b1, 12);
    check("glitch out_valid", out_valid, 0);
    check("glitch fifo_level", fifo_level, 0);

    send_frame(8'h3C, 1'b0, 1'b0, 200);
    line_bits(1'b1, 2);
    check("break fifo_level", fifo_level, 1);
    check("break out_data", out_data, 8'h3C);
    check("break frame_err", out_frame_err, 1);
    pop_one();
    check("break drained", out_valid, 0);

    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b0, 1'b1, 1);
    line_bits(1'b1, 2);
    check("ovr fifo_level", fifo_level, 4);
    check("ovr overrun set", overrun, 1);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("ovr drain%0d data", k), out_data, k);
      pop_one();
    end
    check("ovr empty", out_valid, 0);
    check("ovr level0", fifo_level, 0);
    check("ovr sticky", overrun, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    check("ovr cleared", overrun, 0);

    partial = 8'h55;
    line_bits(1'b0, 1);
    for (int i = 0; i < 4; i++) line_bits(partial[i], 1);
    ser_rx = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("midrst valid%0d", i), out_valid, 0);
    end
    reset = 1'b0;
    line_bits(1'b1, 12);
    check("midrst no partial", out_valid, 0);
    send_frame(8'h99, 1'b0, 1'b1, 1);
    line_bits(1'b1, 2);
    check("midrst fifo_level", fifo_level, 1);
    check("midrst out_data", out_data, 8'h99);
    pop_one();
    check("midrst drained", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised next-generation UART receiver: configurable data width, mid-bit sampling, false-start rejection, framing/break detection, optional parity check.
Received characters, with per-character error flags, go into an internal FIFO drained through a valid/ready stream.
Sits between the board RX pin and any consumer (loopback transmitter, command parser), replacing the single-register, no-backpressure receiver.

Parameters:
DATA_BITS, 8, bits per character, legal 5..9, LSB first on the line
FIFO_DEPTH, 4, FIFO entries, power of two, >= 2
DIV_WIDTH, 32, width of cfg_divider

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ser_rx  in  1  asynchronous serial line, idle high
cfg_divider  in  DIV_WIDTH  bit period minus one, in clk cycles; legal >= 3; static while not idle
cfg_parity_odd  in  1  1 = odd parity, 0 = even; ignored unless UART_RX_PARITY_EN defined
out_data  out  DATA_BITS  head-of-FIFO character
out_frame_err  out  1  head entry's stop bit was sampled low
out_parity_err  out  1  head entry failed parity (constant 0 without macro)
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts head entry when out_valid && out_ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current entry count
overrun  out  1  sticky: a character was dropped because the FIFO was full
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (clk edge with reset=1), valid mid-frame: state IDLE, counters 0, synchroniser flops 1, FIFO emptied.
  Outputs: out_valid=0, fifo_level=0, overrun=0, out_data/err flags=0. A partial frame is discarded.
- ser_rx passes a 2-flop synchroniser (rx_s, reset to 1); all sampling uses rx_s. Fixed 2-cycle input latency.
- divcnt: DIV_WIDTH-bit, cleared on each state entry, increments every cycle otherwise.
  "Bit tick" = divcnt == cfg_divider, so the bit period is cfg_divider+1 cycles.
- IDLE: rx_s==0 -> START, divcnt=0.
- START: at divcnt == cfg_divider>>1, sample rx_s.
  0 -> DATA, bitcnt=0, divcnt=0. 1 -> false start, back to IDLE, nothing pushed.
- DATA: on each bit tick, shift rx_s into shreg MSB side (LSB-first reception), bitcnt++, divcnt=0.
  After the DATA_BITS-th sample -> PARITY (macro defined) or STOP.
- PARITY (macro only): on bit tick, perr = (^shreg ^ rx_s) != cfg_parity_odd -> STOP.
- STOP: on bit tick, ferr = !rx_s; push {perr, ferr, shreg} to FIFO.
  rx_s==1 -> IDLE. rx_s==0 -> BREAK, which waits for rx_s==1, then IDLE; no further pushes while line low.
- Push-to-visibility: entry is visible on out_valid the cycle after the stop tick (registered FIFO write, show-ahead read).
- FIFO: circular, wr/rd pointers $clog2(FIFO_DEPTH) bits wrapping naturally.
  out_data/flags are combinational from the read pointer; pop = out_valid && out_ready.
- Full and push, no pop: entry dropped, pointers unchanged, overrun=1 next cycle.
- Full and push with pop same cycle: both occur, level unchanged, no overrun.
- Empty and push: out_valid=1 next cycle; level stays 0 that cycle (no bypass).
- overrun_clr and a new overrun in the same cycle: overrun stays 1 (set wins).
- fifo_level = wr_ptr - rd_ptr with a full flag, range 0..FIFO_DEPTH.
- cfg_divider change outside IDLE: undefined frame timing; no lock-up (any state returns to IDLE within one frame plus line high).

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state exists; frame = start + DATA_BITS + parity + stop; out_parity_err per entry.
- Undefined: no PARITY state; frame = start + DATA_BITS + stop; out_parity_err tied 0; cfg_parity_odd unused.

Test Plan:
- cfg_divider=86, DATA_BITS=8, send 0xA5 (line bit period 87 clk), out_ready=1 -> one beat out_data=0xA5, ferr=0, perr=0, fifo_level peaks at 1.
- 30-cycle low glitch on idle line, cfg_divider=86 -> no push, out_valid stays 0, state back to IDLE.
- Send 0x3C with stop bit low for 200 bit periods, then high -> single entry 0x3C with out_frame_err=1, no extra entries during the low period.
- out_ready=0, send 5 bytes 0x01..0x05, FIFO_DEPTH=4 -> fifo_level=4, overrun=1, then drain yields 0x01..0x04; overrun_clr pulse -> overrun=0.
- Macro defined, cfg_parity_odd=0, send 0x07 with parity bit 1 then 0x07 with parity bit 0 -> first perr=0, second perr=1.
- reset asserted mid-DATA of a 0x55 frame, released, then 0x99 sent -> only 0x99 emerges, out_valid=0 throughout reset.
